// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: edge-captures completed frames, drops
// framing-error bytes, flags overruns, and presents data first-word-fall-through.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rxDone,
  input  logic          rxErr,
  input  logic [7:0]    rxOut,
  output logic          outValid,
  input  logic          outReady,
  output logic [7:0]    outData,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overrun,
  output logic          frameErr,
  input  logic          clrFlags
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rx_done_prev;

  logic          capture_c;
  logic          pop_c;
  logic          wr_en_c;
  logic          ovr_set_c;
  logic          ferr_set_c;
  logic [AW-1:0] wr_ptr_nxt_c;
  logic [AW-1:0] rd_ptr_nxt_c;
  logic [CW-1:0] count_nxt_c;
  logic [DW-1:0] head_nxt_c;

  // Event decode and next-state of pointers, occupancy and head register.
  always_comb begin
    capture_c    = 1'b0;
    pop_c        = 1'b0;
    wr_en_c      = 1'b0;
    ovr_set_c    = 1'b0;
    ferr_set_c   = 1'b0;
    wr_ptr_nxt_c = wr_ptr;
    rd_ptr_nxt_c = rd_ptr;
    count_nxt_c  = count;
    head_nxt_c   = outData;

    capture_c  = rxDone & ~rx_done_prev;
    pop_c      = outValid & outReady;
    wr_en_c    = capture_c & ~rxErr & (~full | pop_c);
    ovr_set_c  = capture_c & ~rxErr & full & ~pop_c;
    ferr_set_c = capture_c & rxErr;

    if (wr_en_c) begin
      wr_ptr_nxt_c = wr_ptr + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_nxt_c = rd_ptr + AW'(1);
    end

    unique case ({wr_en_c, pop_c})
      2'b10:   count_nxt_c = count + CW'(1);
      2'b01:   count_nxt_c = count - CW'(1);
      default: count_nxt_c = count;
    endcase

    // A byte written this cycle into the slot that becomes the head bypasses memory.
    if (wr_en_c && (wr_ptr == rd_ptr_nxt_c)) begin
      head_nxt_c = rxOut;
    end else begin
      head_nxt_c = mem[rd_ptr_nxt_c];
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      outValid     <= 1'b0;
      full         <= 1'b0;
      overrun      <= 1'b0;
      frameErr     <= 1'b0;
      outData      <= '0;
      rx_done_prev <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt_c;
      rd_ptr       <= rd_ptr_nxt_c;
      count        <= count_nxt_c;
      outValid     <= (count_nxt_c != '0);
      full         <= (count_nxt_c == CW'(DEPTH));
      overrun      <= ovr_set_c | (overrun & ~clrFlags);
      frameErr     <= ferr_set_c | (frameErr & ~clrFlags);
      outData      <= head_nxt_c;
      rx_done_prev <= rxDone;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (rstn && wr_en_c) begin
      mem[wr_ptr] <= rxOut;
    end
  end

endmodule
